axis_upsize_gather: RTL and testbench
=====================================

# axis_upsize_gather

Inbound AXI-Stream width upsizer: accumulates narrow input beats into one wide output word, lowest lane first, and closes the word early on `tlast`. It is the receive-side counterpart to our wide-to-narrow serializing adapter, and sits where a narrow byte stream from a MAC or serial front end joins the wide datapath. It can sustain one input beat per cycle at full rate; a two-deep hold (accumulator plus output register) absorbs backpressure.

## Interface
- `INPUT_DATA_WIDTH`, 8: narrow input data width.
- `INPUT_KEEP_WIDTH`, `INPUT_DATA_WIDTH/8`: input tkeep width.
- `OUTPUT_DATA_WIDTH`, 64: wide output data width.
- `OUTPUT_KEEP_WIDTH`, `OUTPUT_DATA_WIDTH/8`: output tkeep width.
- Derived `CYCLE_COUNT = OUTPUT_KEEP_WIDTH/INPUT_KEEP_WIDTH`. It must be a power of two, ≥2 and ≤128. An elaboration error is raised otherwise.
- The port list below runs name / direction / width / meaning, with clock and reset first.
- `clk` in 1: the single clock. One clock; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous active-low reset. Deassertion is synchronized externally.
- `input_axis_tdata` in `INPUT_DATA_WIDTH`: narrow beat data.
- `input_axis_tkeep` in `INPUT_KEEP_WIDTH`: narrow beat byte enables.
- `input_axis_tvalid` in 1: input beat valid.
- `input_axis_tready` out 1: input ready. It is registered.
- `input_axis_tlast` in 1: last beat of the frame.
- `input_axis_tuser` in 1: frame error flag.
- `output_axis_tdata` out `OUTPUT_DATA_WIDTH`: wide word data.
- `output_axis_tkeep` out `OUTPUT_KEEP_WIDTH`: wide word byte enables.
- `output_axis_tvalid` out 1: wide word valid.
- `output_axis_tready` in 1: downstream ready.
- `output_axis_tlast` out 1: wide word closes the frame.
- `output_axis_tuser` out 1: OR of the `tuser` of every beat in the word.

## Operation
- Slot counter `slot` (8 bits, range 0..`CYCLE_COUNT-1`).
  - Each accepted beat (`tvalid & tready`) writes data and keep into lane `slot`.
  - The counter then increments. Every accepted beat occupies a slot; there is no keep-compaction.
- A word completes when:
  - the beat lands in slot `CYCLE_COUNT-1`, or
  - the accepted beat has `tlast`=1.
- On completion:
  - Lanes above the final slot are forced to data 0 and keep 0.
  - `tlast` = input `tlast` of the completing beat.
  - `tuser` = OR of the `tuser` of all beats in the word.
  - `slot` returns to 0.
- Output register is "free" when `~output_axis_tvalid | output_axis_tready`.
  - Completion with the register free: the word loads into the output register on the same edge.
  - Completion with the register busy: the word stays in the accumulator and the FSM enters HOLD.
- FSM states:
  - EMPTY: `slot`=0, nothing accumulated.
  - FILL: 0 < `slot` < `CYCLE_COUNT`.
  - HOLD: a completed word is waiting. `input_axis_tready`=0.
- Transitions:
  - EMPTY→FILL on accepting a beat that does not complete a word.
  - EMPTY/FILL→EMPTY on completion with the register free.
  - EMPTY/FILL→HOLD on completion with the register busy.
  - HOLD→EMPTY on the first edge where the register is free; the held word moves into the output register.
- `input_axis_tready` register:
  - next value = `state_next != HOLD`.
  - Reset value 0. It goes to 1 on the first edge after `rst_n` deasserts.
- Output register update:
  - Loads on a free edge when a new word is available.
  - Otherwise `tvalid` clears on `output_axis_tready`.
  - Data and keep are don't-care while `tvalid`=0, but are held, not zeroed.
- Reset mid-operation:
  - All state clears asynchronously and any partial word is discarded.
  - Outputs reset to: `output_axis_tvalid`=0, `tdata`=0, `tkeep`=0, `tlast`=0, `tuser`=0, `input_axis_tready`=0.

## Timing
- Latency: the word is visible on `output_axis_tvalid` the cycle after the edge that accepts the completing beat.
- Steady state with `output_axis_tready`=1:
  - `input_axis_tready` stays 1.
  - One output word per `CYCLE_COUNT` input beats.
  - No bubbles are introduced.
- Backpressure:
  - At most one completed word is stalled in the accumulator plus one in the output register.
  - Input then stalls until the output register frees.
  - The first beat of the next word is accepted on the edge after HOLD exits.
- No combinational path from any input to any output. All outputs are registered.

## Structure
- Shared package `axis_pkg` holds:
  - FSM state encodings (`AXIS_GATHER_EMPTY/FILL/HOLD`, 2 bits);
  - the `CYCLE_COUNT` legality check function.
- One sub-module: `axis_out_reg`, the single-entry output register with load/free logic, reusable by other AXI-Stream blocks.

## Test plan
- **Full word, free downstream.** Eight beats 0x11..0x88, keep=1, `tlast` on the 8th, `output_axis_tready`=1 → one word, tdata=0x8877665544332211, tkeep=0xFF, tlast=1, valid the cycle after beat 8.
- **Short frame.** Three beats 0xA1,0xA2,0xA3 with `tlast` on the 3rd → tdata=0x0000000000A3A2A1, tkeep=0x07, tlast=1.
- **Sticky tuser.** `tuser`=1 on beat 2 only of an 8-beat word → output `tuser`=1. The next word, with no `tuser`, has `tuser`=0.
- **Backpressure.** Hold `output_axis_tready`=0 while 16 beats are offered → 8 beats accepted to the output register, 8 more to HOLD, then `input_axis_tready`=0. Raise ready → both words drain in order, intact, and input resumes.
- **Back-to-back single-beat frames.** Every beat carries `tlast` with ready=1 → one word per cycle, each with tkeep=0x01.
- **Reset mid-word.** Pull `rst_n` low after 4 beats → all outputs go to zero immediately. After release, a fresh 8-beat word is emitted with no residue from the discarded beats.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: gather FSM encodings and width-ratio legality check.
package axis_pkg;

    localparam int unsigned AXIS_SLOT_WIDTH = 8;

    typedef enum logic [1:0] {
        AXIS_GATHER_EMPTY = 2'd0,
        AXIS_GATHER_FILL  = 2'd1,
        AXIS_GATHER_HOLD  = 2'd2
    } axis_gather_state_e;

    // Lane count must be a power of two in 2..128 so the slot counter fits 8 bits.
    function automatic bit cycle_count_legal(input int unsigned n);
        return (n >= 2) && (n <= 128) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register; accepts a load only while free.
module axis_out_reg #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [KEEP_WIDTH-1:0] i_keep,
    input  logic                  i_last,
    input  logic                  i_user,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [KEEP_WIDTH-1:0] o_keep,
    output logic                  o_last,
    output logic                  o_user,
    output logic                  o_free_c
);

    assign o_free_c = ~o_valid | i_ready;

    // Payload is held (not zeroed) while idle; only valid clears on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_keep  <= '0;
            o_last  <= 1'b0;
            o_user  <= 1'b0;
        end else if (i_load && o_free_c) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
            o_keep  <= i_keep;
            o_last  <= i_last;
            o_user  <= i_user;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_upsize_gather.sv
// Narrow-to-wide AXI-Stream upsizer: gathers beats lowest lane first, closes early on tlast.
module axis_upsize_gather
    import axis_pkg::*;
#(
    parameter int unsigned INPUT_DATA_WIDTH  = 8,
    parameter int unsigned INPUT_KEEP_WIDTH  = INPUT_DATA_WIDTH / 8,
    parameter int unsigned OUTPUT_DATA_WIDTH = 64,
    parameter int unsigned OUTPUT_KEEP_WIDTH = OUTPUT_DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [INPUT_DATA_WIDTH-1:0]  input_axis_tdata,
    input  logic [INPUT_KEEP_WIDTH-1:0]  input_axis_tkeep,
    input  logic                         input_axis_tvalid,
    output logic                         input_axis_tready,
    input  logic                         input_axis_tlast,
    input  logic                         input_axis_tuser,
    output logic [OUTPUT_DATA_WIDTH-1:0] output_axis_tdata,
    output logic [OUTPUT_KEEP_WIDTH-1:0] output_axis_tkeep,
    output logic                         output_axis_tvalid,
    input  logic                         output_axis_tready,
    output logic                         output_axis_tlast,
    output logic                         output_axis_tuser
);

    localparam int unsigned CYCLE_COUNT = OUTPUT_KEEP_WIDTH / INPUT_KEEP_WIDTH;
    localparam logic [AXIS_SLOT_WIDTH-1:0] LAST_SLOT = AXIS_SLOT_WIDTH'(CYCLE_COUNT - 1);

    generate
        if (!cycle_count_legal(CYCLE_COUNT)) begin : g_bad_cycle_count
            $error("axis_upsize_gather: CYCLE_COUNT must be a power of two in 2..128");
        end
    endgenerate

    axis_gather_state_e           r_state, w_state_next;
    logic [AXIS_SLOT_WIDTH-1:0]   r_slot, w_slot_next;
    logic                         r_in_ready;
    logic [OUTPUT_DATA_WIDTH-1:0] r_acc_data, w_word_data, w_load_data;
    logic [OUTPUT_KEEP_WIDTH-1:0] r_acc_keep, w_word_keep, w_load_keep;
    logic                         r_acc_last, r_acc_user;
    logic                         w_word_user, w_load_last, w_load_user;
    logic                         w_accept, w_complete, w_free, w_load;

    assign input_axis_tready = r_in_ready;
    assign w_accept   = input_axis_tvalid & r_in_ready;
    assign w_complete = w_accept & ((r_slot == LAST_SLOT) | input_axis_tlast);

    // Word as it would stand after this beat: earlier lanes kept, current lane written, upper lanes zero.
    always_comb begin
        w_word_data = '0;
        w_word_keep = '0;
        for (int i = 0; i < CYCLE_COUNT; i++) begin
            if (AXIS_SLOT_WIDTH'(i) < r_slot) begin
                w_word_data[i*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH] = r_acc_data[i*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
                w_word_keep[i*INPUT_KEEP_WIDTH +: INPUT_KEEP_WIDTH] = r_acc_keep[i*INPUT_KEEP_WIDTH +: INPUT_KEEP_WIDTH];
            end else if (AXIS_SLOT_WIDTH'(i) == r_slot) begin
                w_word_data[i*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH] = input_axis_tdata;
                w_word_keep[i*INPUT_KEEP_WIDTH +: INPUT_KEEP_WIDTH] = input_axis_tkeep;
            end
        end
        w_word_user = ((r_slot == '0) ? 1'b0 : r_acc_user) | input_axis_tuser;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= AXIS_GATHER_EMPTY;
            r_slot     <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_slot     <= w_slot_next;
            r_in_ready <= (w_state_next != AXIS_GATHER_HOLD);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_slot_next  = r_slot;
        case (r_state)
            AXIS_GATHER_HOLD: begin
                if (w_free) w_state_next = AXIS_GATHER_EMPTY;
            end
            default: begin
                if (w_complete) begin
                    w_state_next = w_free ? AXIS_GATHER_EMPTY : AXIS_GATHER_HOLD;
                    w_slot_next  = '0;
                end else if (w_accept) begin
                    w_state_next = AXIS_GATHER_FILL;
                    w_slot_next  = r_slot + AXIS_SLOT_WIDTH'(1);
                end
            end
        endcase
    end

    // Accumulator doubles as the stall slot while HOLD waits for the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_data <= '0;
            r_acc_keep <= '0;
            r_acc_last <= 1'b0;
            r_acc_user <= 1'b0;
        end else if (w_accept) begin
            r_acc_data <= w_word_data;
            r_acc_keep <= w_word_keep;
            r_acc_last <= input_axis_tlast;
            r_acc_user <= w_word_user;
        end
    end

    always_comb begin
        w_load      = w_free & ((r_state == AXIS_GATHER_HOLD) | w_complete);
        w_load_data = w_word_data;
        w_load_keep = w_word_keep;
        w_load_last = input_axis_tlast;
        w_load_user = w_word_user;
        if (r_state == AXIS_GATHER_HOLD) begin
            w_load_data = r_acc_data;
            w_load_keep = r_acc_keep;
            w_load_last = r_acc_last;
            w_load_user = r_acc_user;
        end
    end

    axis_out_reg #(
        .DATA_WIDTH (OUTPUT_DATA_WIDTH),
        .KEEP_WIDTH (OUTPUT_KEEP_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_data   (w_load_data),
        .i_keep   (w_load_keep),
        .i_last   (w_load_last),
        .i_user   (w_load_user),
        .i_ready  (output_axis_tready),
        .o_valid  (output_axis_tvalid),
        .o_data   (output_axis_tdata),
        .o_keep   (output_axis_tkeep),
        .o_last   (output_axis_tlast),
        .o_user   (output_axis_tuser),
        .o_free_c (w_free)
    );

endmodule

// File: tb/tb_axis_upsize_gather.sv
// Bench for axis_upsize_gather: queue-based word model compared every cycle plus literal word checks.
module tb_axis_upsize_gather;

    localparam int unsigned CC = 8;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [0:0]  in_keep;
    logic        in_valid, in_ready, in_last, in_user;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic        out_valid, out_ready, out_last, out_user;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    axis_upsize_gather dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .input_axis_tdata   (in_data),
        .input_axis_tkeep   (in_keep),
        .input_axis_tvalid  (in_valid),
        .input_axis_tready  (in_ready),
        .input_axis_tlast   (in_last),
        .input_axis_tuser   (in_user),
        .output_axis_tdata  (out_data),
        .output_axis_tkeep  (out_keep),
        .output_axis_tvalid (out_valid),
        .output_axis_tready (out_ready),
        .output_axis_tlast  (out_last),
        .output_axis_tuser  (out_user)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h required %0h", name, got, exp);
        else n_pass++;
    endtask

    // Model: partial beat list, at most one held word, one output word; words handed downstream are logged.
    logic        m_ov, m_held, m_ready;
    word_t       m_out, m_hold_w;
    logic [63:0] p_data;
    logic [7:0]  p_keep;
    logic        p_user;
    int          p_cnt;
    word_t       emit_q[$];

    always @(posedge clk or negedge rst_n) begin : model
        word_t w;
        logic  free, loaded;
        if (!rst_n) begin
            m_ov = 0; m_held = 0; m_ready = 0; m_out = '0; m_hold_w = '0;
            p_data = '0; p_keep = '0; p_user = 0; p_cnt = 0;
        end else begin
            free   = !m_ov || out_ready;
            loaded = 0;
            if (m_ov && out_ready) emit_q.push_back(m_out);
            if (m_held) begin
                if (free) begin m_out = m_hold_w; loaded = 1; m_held = 0; end
            end else if (in_valid && m_ready) begin
                p_data[p_cnt*8 +: 8] = in_data;
                p_keep[p_cnt]        = in_keep[0];
                p_user               = p_user | in_user;
                p_cnt++;
                if (p_cnt == CC || in_last) begin
                    w = '{d: p_data, k: p_keep, l: in_last, u: p_user};
                    p_data = '0; p_keep = '0; p_user = 0; p_cnt = 0;
                    if (free) begin m_out = w; loaded = 1; end
                    else begin m_hold_w = w; m_held = 1; end
                end
            end
            if (loaded) m_ov = 1;
            else if (out_ready) m_ov = 0;
            m_ready = !m_held;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("tready", 64'(in_ready), 64'(m_ready));
            chk("tvalid", 64'(out_valid), 64'(m_ov));
            if (m_ov) begin
                chk("tdata", out_data, m_out.d);
                chk("tkeep", 64'(out_keep), 64'(m_out.k));
                chk("tlast", 64'(out_last), 64'(m_out.l));
                chk("tuser", 64'(out_user), 64'(m_out.u));
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l, input logic u);
        int n = 0;
        @(negedge clk);
        in_valid = 1; in_data = d; in_keep = 1'b1; in_last = l; in_user = u;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            n_total++;
            $display("FAIL send_timeout: input_axis_tready got 0 required 1 within 64 cycles");
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 0; in_last = 0; in_user = 0;
        end
    endtask

    task automatic pop_chk(input string name, input word_t exp);
        word_t w;
        if (emit_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: got no word required %0h", name, exp.d);
        end else begin
            w = emit_q.pop_front();
            chk({name, "_data"}, w.d, exp.d);
            chk({name, "_keep"}, 64'(w.k), 64'(exp.k));
            chk({name, "_last"}, 64'(w.l), 64'(exp.l));
            chk({name, "_user"}, 64'(w.u), 64'(exp.u));
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_tvalid"}, 64'(out_valid), 64'd0);
        chk({name, "_tdata"},  out_data, 64'd0);
        chk({name, "_tkeep"},  64'(out_keep), 64'd0);
        chk({name, "_tlast"},  64'(out_last), 64'd0);
        chk({name, "_tuser"},  64'(out_user), 64'd0);
        chk({name, "_tready"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_data = '0; in_keep = '0; in_last = 0; in_user = 0; out_ready = 1;
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        #2 rst_n = 1;
        #1 chk("tready_before_first_edge", 64'(in_ready), 64'd0);

        // Full word with tlast on the 8th beat
        for (int i = 0; i < 8; i++) send(8'(8'h11 * (i + 1)), i == 7, 0);
        idle(1);
        chk("full_latency_tvalid", 64'(out_valid), 64'd1);
        chk("full_latency_tdata", out_data, 64'h8877665544332211);
        idle(2);
        pop_chk("full", '{d: 64'h8877665544332211, k: 8'hFF, l: 1'b1, u: 1'b0});

        // Short frame
        send(8'hA1, 0, 0); send(8'hA2, 0, 0); send(8'hA3, 1, 0);
        idle(3);
        pop_chk("short", '{d: 64'h0000000000A3A2A1, k: 8'h07, l: 1'b1, u: 1'b0});

        // Sticky tuser, cleared for the following word
        for (int i = 0; i < 8; i++) send(8'(8'h30 + i), 0, i == 1);
        for (int i = 0; i < 8; i++) send(8'(8'h40 + i), 0, 0);
        idle(3);
        pop_chk("user_set", '{d: 64'h3736353433323130, k: 8'hFF, l: 1'b0, u: 1'b1});
        pop_chk("user_clr", '{d: 64'h4746454443424140, k: 8'hFF, l: 1'b0, u: 1'b0});

        // Backpressure: one word in the output register, one held, then input stalls
        out_ready = 0;
        for (int i = 0; i < 16; i++) send(8'(i + 1), 0, 0);
        idle(4);
        chk("bp_tready_stalled", 64'(in_ready), 64'd0);
        chk("bp_tvalid", 64'(out_valid), 64'd1);
        chk("bp_first_word", out_data, 64'h0807060504030201);
        chk("bp_nothing_emitted", 64'(emit_q.size()), 64'd0);
        out_ready = 1;
        idle(4);
        pop_chk("bp_w0", '{d: 64'h0807060504030201, k: 8'hFF, l: 1'b0, u: 1'b0});
        pop_chk("bp_w1", '{d: 64'h100F0E0D0C0B0A09, k: 8'hFF, l: 1'b0, u: 1'b0});
        chk("bp_resumed", 64'(in_ready), 64'd1);

        // Back-to-back single-beat frames
        for (int i = 0; i < 6; i++) send(8'(8'hC0 + i), 1, 0);
        idle(3);
        for (int i = 0; i < 6; i++)
            pop_chk("single", '{d: 64'(8'hC0 + i), k: 8'h01, l: 1'b1, u: 1'b0});

        // Reset mid-word discards the partial beats
        emit_q.delete();
        for (int i = 0; i < 4; i++) send(8'(8'hE1 + i), 0, 1);
        @(negedge clk);
        in_valid = 0;
        #2 rst_n = 0;
        #1 chk_reset_outputs("midreset");
        @(negedge clk);
        #2 rst_n = 1;
        for (int i = 0; i < 8; i++) send(8'(8'h21 + i), i == 7, 0);
        idle(3);
        pop_chk("post_reset", '{d: 64'h2827262524232221, k: 8'hFF, l: 1'b1, u: 1'b0});

        // Random traffic against the model
        repeat (3000) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_keep   = 1'($urandom_range(0, 1));
            in_last   = ($urandom_range(0, 4) == 0);
            in_user   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
        end
        @(negedge clk);
        out_ready = 1;
        idle(10);
        chk("rand_drained", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
